decoder_2to4: RTL and testbench
===============================

# decoder_2to4

Registered 2-to-4 one-hot decoder with enable and output-valid flag. Converts a 2-bit binary select into a 4-bit one-hot word, bit `in` set. It is used as a leaf block wherever a binary index must drive four mutually exclusive select or enable lines. The output is registered, so the decoded select drives downstream logic glitch-free.

## Interface
- Parameters: none. Widths are fixed at 2 in and 4 out and come from the shared package.
- `clk`  input  1  rising-edge clock; all state updates on this edge.
- `rst`  input  1  reset: synchronous and active-high.
- `en`  input  1  decode enable, sampled on `clk`.
- `in`  input  2  binary select index.
- `out`  output  4  registered one-hot decode of `in`.
- `out_valid`  output  1  high when `out` holds a decode made with `en`=1.

## Operation
- Decode function: `out[k]` = 1 if and only if `in` == k.
  - 00 -> 0001
  - 01 -> 0010
  - 10 -> 0100
  - 11 -> 1000
- At each rising edge with `rst`=1: `out` <= 0000 and `out_valid` <= 0. Reset overrides `en` and `in`.
- At each rising edge with `rst`=0 and `en`=1: `out` <= decode(`in`) and `out_valid` <= 1.
- At each rising edge with `rst`=0 and `en`=0: `out_valid` <= 0. `out` follows the configuration (see Configuration); the default is `out` <= 0000.
- Invariant: `out` is always either 0000 or exactly one-hot. It is never multi-hot.
- No state machine. The only state is the `out` and `out_valid` registers.
- X or Z on `in` while `en`=1 is not supported; the behaviour in that case is not specified.

## Timing
- Latency is 1 cycle: `in` and `en` sampled at edge N appear on `out` and `out_valid` immediately after edge N.
- Throughput is 1 decode per cycle. A new `in` is accepted every cycle, with no handshake and no backpressure.
- Both outputs are driven directly from flops, with no combinational path from input to output.
- Reset values: `out` = 0000, `out_valid` = 0.
- Reset asserted mid-stream: the outputs clear at the first edge where `rst`=1. At the first edge after `rst` deasserts, `in` is decoded if `en`=1.
- `en` toggling every cycle: `out_valid` tracks `en` exactly, delayed by one cycle.

## Configuration
- Macro `DECODER_2TO4_HOLD_EN`:
  - Defined: when `en`=0 (and `rst`=0), `out` holds its previous value and `out_valid` <= 0.
  - Not defined: when `en`=0, `out` <= 0000 and `out_valid` <= 0.
- The reset behaviour and the `en`=1 behaviour are identical in both builds.

## Structure
- Shared package `decoder_pkg` holds:
  - `DEC_IN_W` = 2
  - `DEC_OUT_W` = 4
  - typedefs `dec_sel_t` (logic [1:0]) and `dec_onehot_t` (logic [3:0])
  - a pure function `dec_onehot(dec_sel_t)` returning `dec_onehot_t`
- One sub-module is natural: `decoder_2to4_core`. It holds the purely combinational decode and instantiates `dec_onehot`.
- The top level adds the enable/hold muxing and the output registers.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `en`=1 and `in`=11 -> `out`=0000 and `out_valid`=0 on both cycles.
- Full sweep: with `en`=1, drive `in`=00, 01, 10, 11 on consecutive cycles -> `out`=0001, 0010, 0100, 1000 one cycle later each, with `out_valid`=1 throughout.
- Enable low: after decoding `in`=10 (`out`=0100), set `en`=0 -> the next cycle gives `out`=0000 and `out_valid`=0. With `DECODER_2TO4_HOLD_EN` defined, `out` stays 0100 and `out_valid`=0.
- Reset mid-stream: with `out`=1000, assert `rst` for 1 cycle while `en`=1 and `in`=01 -> `out`=0000; after deassertion, the next edge gives `out`=0010.
- Enable toggling: alternate `en`=1/0 every cycle with `in`=01 -> `out_valid` alternates 1/0 delayed by one cycle. `out` alternates 0010/0000, or holds 0010 under `DECODER_2TO4_HOLD_EN`.
- Invariant check: randomise `in`, `en` and `rst` for 1000 cycles -> `out` is always 0000 or one-hot, and equals decode of the previous-cycle `in` whenever `out_valid`=1.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths, types and the one-hot decode function for the 2-to-4 decoder.
package decoder_pkg;

    localparam int DEC_IN_W  = 2;
    localparam int DEC_OUT_W = 4;

    typedef logic [DEC_IN_W-1:0]  dec_sel_t;
    typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

    function automatic dec_onehot_t dec_onehot(input dec_sel_t sel);
        dec_onehot_t result;
        result = '0;
        for (int k = 0; k < DEC_OUT_W; k++) begin
            result[k] = (sel == dec_sel_t'(k));
        end
        return result;
    endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// Purely combinational 2-to-4 one-hot decode; no state.
module decoder_2to4_core
    import decoder_pkg::*;
(
    input  logic [1:0] sel,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = dec_onehot(sel);
    end

endmodule

// File: rtl/decoder_2to4.sv
// Registered 2-to-4 one-hot decoder with enable and output-valid flag.
// Build option: define DECODER_2TO4_HOLD_EN to hold `out` while en=0 instead of clearing it.
module decoder_2to4
    import decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] in,
    output logic [3:0] out,
    output logic       out_valid
);

    dec_onehot_t decoded;

    decoder_2to4_core u_core (
        .sel    (in),
        .onehot (decoded)
    );

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out       <= decoded;
            out_valid <= 1'b1;
        end else begin
`ifdef DECODER_2TO4_HOLD_EN
            out       <= out;
`else
            out       <= '0;
`endif
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench for decoder_2to4: directed vector table, then randomized run vs. a reference model.
`timescale 1ns/1ps
module tb_decoder_2to4;

`ifdef DECODER_2TO4_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] sel;
        logic [3:0] exp_out;
        logic       exp_valid;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic [3:0] dut_out;
    logic       dut_valid;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] model_out;
    logic       model_valid;

    vec_t vecs[16];

    always #5 clk = ~clk;

    decoder_2to4 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (sel),
        .out       (dut_out),
        .out_valid (dut_valid)
    );

    task automatic check(input string name, input logic [3:0] act_out, input logic act_valid,
                         input logic [3:0] exp_out, input logic exp_valid);
        vectors++;
        if (act_out !== exp_out || act_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL %s: got out=%b valid=%b, expected out=%b valid=%b",
                     name, act_out, act_valid, exp_out, exp_valid);
        end
    endtask

    // Apply inputs, clock once, and sample just after the edge.
    task automatic step(input logic r, input logic e, input logic [1:0] s);
        rst = r;
        en  = e;
        sel = s;
        @(posedge clk);
        #1;
    endtask

    // Reference: decode is "bit number sel set", i.e. 1 << sel.
    task automatic model_update(input logic r, input logic e, input logic [1:0] s);
        if (r) begin
            model_out   = 4'b0000;
            model_valid = 1'b0;
        end else if (e) begin
            model_out   = 4'(1 << int'(s));
            model_valid = 1'b1;
        end else begin
            model_out   = HOLD ? model_out : 4'b0000;
            model_valid = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] hold_0100;
        logic [3:0] hold_0010;
        logic       r_r, r_e;
        logic [1:0] r_s;
        logic [1:0] prev_sel;

        hold_0100 = HOLD ? 4'b0100 : 4'b0000;
        hold_0010 = HOLD ? 4'b0010 : 4'b0000;

        // rst, en, sel, expected out, expected out_valid
        vecs[0]  = '{1'b1, 1'b1, 2'd3, 4'b0000, 1'b0};  // reset cycle 1
        vecs[1]  = '{1'b1, 1'b1, 2'd3, 4'b0000, 1'b0};  // reset cycle 2
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 4'b0001, 1'b1};  // sweep
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 1'b1};  // enable low after 10
        vecs[7]  = '{1'b0, 1'b0, 2'd2, hold_0100, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b1};  // reset mid-stream
        vecs[9]  = '{1'b1, 1'b1, 2'd1, 4'b0000, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'd1, hold_0010, 1'b0}; // enable toggling
        vecs[12] = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 2'd1, hold_0010, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 2'd1, hold_0010, 1'b0};

        rst = 1'b1;
        en  = 1'b0;
        sel = 2'd0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].sel);
            check($sformatf("dir[%0d]", i), dut_out, dut_valid, vecs[i].exp_out, vecs[i].exp_valid);
        end

        // Re-enter the model from a known reset state before the random run.
        step(1'b1, 1'b0, 2'd0);
        model_update(1'b1, 1'b0, 2'd0);
        check("rand_reset", dut_out, dut_valid, model_out, model_valid);

        prev_sel = 2'd0;
        for (int c = 0; c < 1000; c++) begin
            r_r = ($urandom_range(15) == 0);
            r_e = $urandom_range(1);
            r_s = 2'($urandom_range(3));
            step(r_r, r_e, r_s);
            model_update(r_r, r_e, r_s);
            prev_sel = r_s;
            check($sformatf("rand[%0d]", c), dut_out, dut_valid, model_out, model_valid);
            vectors++;
            if ($countones(dut_out) > 1 ||
                (dut_valid === 1'b1 && dut_out !== 4'(1 << int'(prev_sel)))) begin
                miscompares++;
                $display("FAIL inv[%0d]: got out=%b valid=%b, expected 0000/one-hot decode of sel=%0d",
                         c, dut_out, dut_valid, prev_sel);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
